// File: rtl/shape_source.sv
// Shape channel source: packs ELEM_W-bit elements into ARRAY_LEN-element messages, 2-deep output FIFO.
// Optional feature: define SHAPE_SOURCE_STATS_EN to add the saturating msg_count output.
module shape_source #(
  parameter int ARRAY_LEN = 4,
  parameter int ELEM_W    = 39,
  localparam int LEN_W    = $clog2(ARRAY_LEN + 1),
  localparam int IDX_W    = (ARRAY_LEN > 1) ? $clog2(ARRAY_LEN) : 1,
  localparam int ARR_W    = ARRAY_LEN * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic              shape_valid,
  input  logic              shape_ready,
  output logic [ARR_W-1:0]  shape_array1,
  output logic [LEN_W-1:0]  shape_len
`ifdef SHAPE_SOURCE_STATS_EN
  ,
  output logic [15:0]       msg_count
`endif
);

  logic [IDX_W-1:0] idx_q;
  logic [ARR_W-1:0] asm_q;
  logic [ARR_W-1:0] merged;
  logic             accept;
  logic             close;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  logic [ARR_W-1:0] mem_arr [2];
  logic [LEN_W-1:0] mem_len [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  assign full        = (count == 2'd2);
  assign empty       = (count == 2'd0);
  assign in_ready    = !full && !rst;
  assign accept      = in_valid && in_ready;
  assign close       = in_last || (idx_q == IDX_W'(ARRAY_LEN - 1));
  assign push        = accept && close;
  assign shape_valid = !empty;
  assign pop         = shape_valid && shape_ready;
  assign shape_array1 = mem_arr[rd_ptr];
  assign shape_len    = mem_len[rd_ptr];

  // The closing element is merged combinationally so the whole message is pushed on that beat.
  always_comb begin
    merged = asm_q;
    merged[int'(idx_q) * ELEM_W +: ELEM_W] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (close) begin
        idx_q <= '0;
        asm_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
        asm_q <= merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_arr[i] <= '0;
        mem_len[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_arr[wr_ptr] <= merged;
        mem_len[wr_ptr] <= LEN_W'(idx_q) + LEN_W'(1);
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (!push && pop) begin
        count <= count - 2'd1;
      end
    end
  end

`ifdef SHAPE_SOURCE_STATS_EN
  logic [15:0] msg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q <= '0;
    end else if (pop && (msg_q != 16'hFFFF)) begin
      msg_q <= msg_q + 16'd1;
    end
  end

  assign msg_count = msg_q;
`endif

endmodule
